joy_conditioner: RTL

- Parametrised successor to the single-player 8-way joystick resolver.
- Serves NUM_PLAYERS players. Per player it applies:
  - optional 90° input rotation for horizontal cabinets;
  - input synchronisation;
  - a selectable SOCD policy for opposite directions (up+down, left+right);
  - an optional 4-way restriction;
  - per-button autofire.
- Sits between hps_io/keyboard merge logic and the game core's active-low input ports. Output inversion stays in the top level.

---
 rtl/joy_pkg.sv | 40 ++++
 rtl/joy_conditioner_if.sv | 16 +
 rtl/joy_channel.sv | 127 ++++++++++++
 rtl/joy_conditioner.sv | 49 ++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared constants, types and the per-axis SOCD helper for the joystick conditioner.
package joy_pkg;

  localparam logic [1:0] SOCD_LAST    = 2'd0;
  localparam logic [1:0] SOCD_NEUTRAL = 2'd1;
  localparam logic [1:0] SOCD_FIRST   = 2'd2;
  localparam logic [1:0] SOCD_RAW     = 2'd3;

  // Bit positions inside a player's {U,D,L,R} nibble.
  localparam int DIR_U = 3;
  localparam int DIR_D = 2;
  localparam int DIR_L = 1;
  localparam int DIR_R = 0;

  // Vertical is encoded as 0 so the reset value of last_axis is vertical.
  typedef enum logic {
    AXIS_V = 1'b0,
    AXIS_H = 1'b1
  } axis_t;

  // Resolves one axis. held = {A,B} where A is L (or U), the side that wins ties.
  // last_a / first_a are 1 when A was the last / first pressed side.
  function automatic logic [1:0] socd_resolve(input logic [1:0] mode,
                                              input logic [1:0] held,
                                              input logic       last_a,
                                              input logic       first_a);
    logic [1:0] res;
    res = held;
    if (held == 2'b11) begin
      case (mode)
        SOCD_LAST:    res = last_a  ? 2'b10 : 2'b01;
        SOCD_NEUTRAL: res = 2'b00;
        SOCD_FIRST:   res = first_a ? 2'b10 : 2'b01;
        default:      res = held;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/joy_conditioner_if.sv
// Player-facing bus: raw directions/fire in, conditioned directions/fire out.
interface joy_conditioner_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int FIRE_BITS   = 2
);
  logic [NUM_PLAYERS*4-1:0]         joy_in;
  logic [NUM_PLAYERS*FIRE_BITS-1:0] fire_in;
  logic [NUM_PLAYERS*FIRE_BITS-1:0] af_enable;
  logic [NUM_PLAYERS*4-1:0]         joy_out;
  logic [NUM_PLAYERS*FIRE_BITS-1:0] fire_out;

  // Plain level signals, no handshake: the source drives the raw inputs every
  // cycle and the conditioner presents registered outputs every cycle.
  modport master (output joy_in, fire_in, af_enable, input joy_out, fire_out);
  modport slave  (input joy_in, fire_in, af_enable, output joy_out, fire_out);
endinterface

// File: rtl/joy_channel.sv
// One player: synchroniser, edge detect, SOCD, 4-way restriction and autofire.
module joy_channel
  import joy_pkg::*;
#(
  parameter int FIRE_BITS   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int AF_DIV      = 3
) (
  input  logic                 clk,
  input  logic                 RESET_N,
  input  logic [1:0]           socd_mode,
  input  logic                 four_way,
  input  logic                 af_tick,
  input  logic [3:0]           joy_raw,
  input  logic [FIRE_BITS-1:0] fire_raw,
  input  logic [FIRE_BITS-1:0] af_enable,
  output logic [3:0]           joy_out,
  output logic [FIRE_BITS-1:0] fire_out
);

  localparam int W = 4 + FIRE_BITS;
  localparam logic [7:0] AF_LAST = 8'(AF_DIV - 1);

  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] s, s_prev, rise;
  logic [3:0] js, jn, joy_d;
  logic [FIRE_BITS-1:0] fs, fn, fire_d, phase_q, phase_d;
  logic [7:0] cnt_q [FIRE_BITS];
  logic [7:0] cnt_d [FIRE_BITS];
  logic last_h, last_v, first_h, first_v;
  logic last_h_d, last_v_d, first_h_d, first_v_d;
  axis_t last_axis, last_axis_d;
  logic [1:0] res_h, res_v;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_prev;
  assign js   = s[3:0];
  assign jn   = rise[3:0];
  assign fs   = s[W-1:4];
  assign fn   = rise[W-1:4];

  // Synchroniser chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_prev <= '0;
    end else begin
      sync_q[0] <= {fire_raw, joy_raw};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_prev <= s;
    end
  end

  // Next-state of the press-history flags and the resolved direction nibble.
  // The next values feed resolution so a fresh press wins in the same cycle.
  always_comb begin
    last_h_d = last_h;
    if (jn[DIR_L])      last_h_d = 1'b1;
    else if (jn[DIR_R]) last_h_d = 1'b0;
    last_v_d = last_v;
    if (jn[DIR_U])      last_v_d = 1'b1;
    else if (jn[DIR_D]) last_v_d = 1'b0;
    // The side held before the opposite arrived is the opposite of the new one;
    // a simultaneous onset lands on A (L/U).
    first_h_d = first_h;
    if (js[DIR_L] && js[DIR_R] && (jn[DIR_L] || jn[DIR_R])) first_h_d = jn[DIR_R];
    first_v_d = first_v;
    if (js[DIR_U] && js[DIR_D] && (jn[DIR_U] || jn[DIR_D])) first_v_d = jn[DIR_D];
    last_axis_d = last_axis;
    if (jn[DIR_U] || jn[DIR_D])      last_axis_d = AXIS_V;
    else if (jn[DIR_L] || jn[DIR_R]) last_axis_d = AXIS_H;
    res_h = socd_resolve(socd_mode, {js[DIR_L], js[DIR_R]}, last_h_d, first_h_d);
    res_v = socd_resolve(socd_mode, {js[DIR_U], js[DIR_D]}, last_v_d, first_v_d);
    joy_d = {res_v, res_h};
    if (four_way && (|res_v) && (|res_h))
      joy_d = (last_axis_d == AXIS_V) ? {res_v, 2'b00} : {2'b00, res_h};
  end

  // Autofire phase/counter per button; a fresh press starts in the on phase.
  always_comb begin
    for (int b = 0; b < FIRE_BITS; b++) begin
      phase_d[b] = phase_q[b];
      cnt_d[b]   = cnt_q[b];
      if (!fs[b]) begin
        phase_d[b] = 1'b0;
        cnt_d[b]   = 8'd0;
      end else if (fn[b]) begin
        phase_d[b] = 1'b1;
        cnt_d[b]   = 8'd0;
      end else if (af_tick) begin
        if (cnt_q[b] == AF_LAST) begin
          cnt_d[b]   = 8'd0;
          phase_d[b] = ~phase_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 8'd1;
        end
      end
      fire_d[b] = af_enable[b] ? (fs[b] & phase_d[b]) : fs[b];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      last_h    <= 1'b0;
      last_v    <= 1'b0;
      first_h   <= 1'b0;
      first_v   <= 1'b0;
      last_axis <= AXIS_V;
      phase_q   <= '0;
      for (int b = 0; b < FIRE_BITS; b++) cnt_q[b] <= 8'd0;
      joy_out   <= 4'd0;
      fire_out  <= '0;
    end else begin
      last_h    <= last_h_d;
      last_v    <= last_v_d;
      first_h   <= first_h_d;
      first_v   <= first_v_d;
      last_axis <= last_axis_d;
      phase_q   <= phase_d;
      for (int b = 0; b < FIRE_BITS; b++) cnt_q[b] <= cnt_d[b];
      joy_out   <= joy_d;
      fire_out  <= fire_d;
    end
  end

endmodule

// File: rtl/joy_conditioner.sv
// Multi-player joystick conditioner: rotation mux in front of one channel per player.
module joy_conditioner
  import joy_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int FIRE_BITS   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int AF_DIV      = 3
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             rotate,
  input  logic [1:0]       socd_mode,
  input  logic             four_way,
  input  logic             af_tick,
  joy_conditioner_if.slave bus
);

  logic [NUM_PLAYERS*4-1:0]         joy_out_w;
  logic [NUM_PLAYERS*FIRE_BITS-1:0] fire_out_w;

  assign bus.joy_out  = joy_out_w;
  assign bus.fire_out = fire_out_w;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [3:0] j_raw, j_eff;
    assign j_raw = bus.joy_in[4*p +: 4];
    // Horizontal cabinet: U<-L, D<-R, L<-D, R<-U.
    assign j_eff = rotate ? {j_raw[DIR_L], j_raw[DIR_R], j_raw[DIR_D], j_raw[DIR_U]} : j_raw;

    joy_channel #(
      .FIRE_BITS   (FIRE_BITS),
      .SYNC_STAGES (SYNC_STAGES),
      .AF_DIV      (AF_DIV)
    ) u_channel (
      .clk       (clk),
      .RESET_N   (RESET_N),
      .socd_mode (socd_mode),
      .four_way  (four_way),
      .af_tick   (af_tick),
      .joy_raw   (j_eff),
      .fire_raw  (bus.fire_in[FIRE_BITS*p +: FIRE_BITS]),
      .af_enable (bus.af_enable[FIRE_BITS*p +: FIRE_BITS]),
      .joy_out   (joy_out_w[4*p +: 4]),
      .fire_out  (fire_out_w[FIRE_BITS*p +: FIRE_BITS])
    );
  end

endmodule
